minterm_window_detector: RTL and testbench

Serial-input, parametrised successor to the team's 3-input fixed-minterm function block. Each accepted bit is shifted into an N-bit window, and the window value is looked up in a run-time-loadable 2^N-bit minterm mask. Matches are reported as a registered flag and tallied in a saturating counter. It sits between a serial bit source and control logic that needs pattern/minterm hits over the recent input history.

---
 rtl/minterm_window_detector.sv | 60 ++++++
 tb/tb_minterm_window_detector.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/minterm_window_detector.sv
// minterm_window_detector: serial N-bit window looked up in a loadable minterm mask; MWD_OVERLAP_EN selects overlapping detection
module minterm_window_detector #(
   parameter int N = 3,
   parameter int CNT_W = 8,
   parameter logic [(1<<N)-1:0] MASK = 8'h46
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   input  logic                x,
   input  logic                mask_load,
   input  logic [(1<<N)-1:0]   mask_in,
   output logic                z,
   output logic                z_valid,
   output logic [CNT_W-1:0]    match_count,
   output logic [N-1:0]        window
);
   localparam int FW = $clog2(N + 1);
   localparam logic [FW-1:0] FULL = FW'(N);
   localparam logic [FW-1:0] LAST = FW'(N - 1);
   logic [(1<<N)-1:0] mask;
   logic [FW-1:0] fill, next_fill;
   logic [N-1:0] next_window;
   logic eval, hit;
   // shifted window, evaluation gate and next fill level
   always_comb begin
      next_window = {window[N-2:0], x};
      eval = in_valid && fill >= LAST;
      hit = eval && mask[next_window];
`ifdef MWD_OVERLAP_EN
      next_fill = (fill == FULL) ? FULL : fill + 1'b1;
`else
      next_fill = hit ? '0 : (fill == FULL) ? FULL : fill + 1'b1;
`endif
   end
   // window, fill, result flag and saturating match counter
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         window <= '0;
         fill <= '0;
         z <= 1'b0;
         z_valid <= 1'b0;
         match_count <= '0;
      end else begin
         z_valid <= eval;
         if (in_valid) begin
            window <= next_window;
            fill <= next_fill;
         end
         if (eval) z <= hit;
         if (hit && match_count != '1) match_count <= match_count + 1'b1;
      end
   end
   // mask register survives clr; an evaluation in the load cycle sees the old mask
   always_ff @(posedge clk) begin
      if (rst) mask <= MASK;
      else if (mask_load) mask <= mask_in;
   end
endmodule

// File: tb/tb_minterm_window_detector.sv
// tb_minterm_window_detector: randomized and directed checks against a bit-history reference model
module tb_minterm_window_detector;
   logic clk = 0, rst = 0, clr = 0, in_valid = 0, x = 0, mask_load = 0;
   logic [7:0] mask_in = 0;
   logic z, z_valid;
   logic [7:0] match_count;
   logic [2:0] window;
   int n_tests = 0, n_fail = 0;
   int m_win, m_fresh, m_cnt;
   logic m_z, m_zv;
   logic [7:0] m_mask;

   minterm_window_detector #(.N(3), .CNT_W(8), .MASK(8'h46)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .x(x),
      .mask_load(mask_load), .mask_in(mask_in), .z(z), .z_valid(z_valid),
      .match_count(match_count), .window(window)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_z"}, 32'(z), 32'(m_z));
      check({tag, "_zv"}, 32'(z_valid), 32'(m_zv));
      check({tag, "_cnt"}, 32'(match_count), m_cnt);
      check({tag, "_win"}, 32'(window), m_win);
   endtask

   task automatic model_clear();
      m_win = 0;
      m_fresh = 0;
      m_z = 0;
      m_zv = 0;
      m_cnt = 0;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1; clr = 0; in_valid = 1; x = 1; mask_load = 1; mask_in = 8'h01;
      @(posedge clk);
      model_clear();
      m_mask = 8'h46;
      #1 check_all(tag);
   endtask

   task automatic step(input string tag, input logic v, input logic xb, input logic ml,
                       input logic [7:0] mi, input logic c);
      @(negedge clk);
      rst = 0; in_valid = v; x = xb; mask_load = ml; mask_in = mi; clr = c;
      @(posedge clk);
      if (c) model_clear();
      else begin
         m_zv = 0;
         if (v) begin
            m_win = (m_win * 2 + int'(xb)) % 8;
            m_fresh = (m_fresh + 1 > 3) ? 3 : m_fresh + 1;
            if (m_fresh == 3) begin
               m_zv = 1;
               m_z = m_mask[m_win];
               if (m_z) begin
                  m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
`ifndef MWD_OVERLAP_EN
                  m_fresh = 0;
`endif
               end
            end
         end
      end
      if (ml) m_mask = mi;
      #1 check_all(tag);
   endtask

   task automatic acc(input string tag, input logic xb);
      step(tag, 1, xb, 0, 8'h00, 0);
   endtask

   initial begin
      do_reset("rst0");
      check("rst0_zero_z", 32'(z), 0);
      check("rst0_zero_cnt", 32'(match_count), 0);
      acc("fill0", 0);
      acc("fill1", 0);
      check("fill_no_zv", 32'(z_valid), 0);
      acc("fill2", 1);
      check("fill_z", 32'(z), 1);
      check("fill_zv", 32'(z_valid), 1);
      check("fill_win", 32'(window), 1);
      check("fill_cnt", 32'(match_count), 1);
      acc("ovl3", 0);
`ifdef MWD_OVERLAP_EN
      check("ovl_cnt", 32'(match_count), 2);
      check("ovl_zv", 32'(z_valid), 1);
`else
      check("novl_cnt", 32'(match_count), 1);
      check("novl_zv", 32'(z_valid), 0);
      acc("novl4", 1);
      acc("novl5", 1);
      check("novl_z011", 32'(z), 0);
      check("novl_zv011", 32'(z_valid), 1);
`endif
      step("idle", 0, 1, 0, 8'h00, 0);
      check("idle_zv", 32'(z_valid), 0);
      do_reset("rst1");
      acc("race0", 0);
      acc("race1", 1);
      acc("race2", 1);
      step("race_ld", 1, 1, 1, 8'h80, 0);
      check("race_old_mask", 32'(z), 0);
      acc("race_new", 1);
      check("race_new_mask", 32'(z), 1);
      do_reset("rst2");
      acc("clr0", 0);
      acc("clr1", 0);
      step("clr", 0, 0, 0, 8'h00, 1);
      acc("clr_a", 1);
      check("clr_a_zv", 32'(z_valid), 0);
      acc("clr_b", 1);
      check("clr_b_zv", 32'(z_valid), 0);
      acc("clr_c", 1);
      check("clr_c_zv", 32'(z_valid), 1);
      step("ld01", 0, 0, 1, 8'h01, 0);
      do_reset("rst_mask");
      check("rst_mask_zv", 32'(z_valid), 0);
      acc("rm0", 0);
      acc("rm1", 0);
      acc("rm2", 1);
      check("rst_mask_46", 32'(z), 1);
      step("ldff", 0, 0, 1, 8'hFF, 0);
      for (int i = 0; i < 800; i++) acc("sat", 1'($urandom));
      check("sat_cnt", 32'(match_count), 255);
      step("clr_ldb", 1, 1, 1, 8'h5A, 1);
      for (int i = 0; i < 3000; i++) begin
         int r = $urandom_range(0, 127);
         if (r == 0) do_reset("rnd_rst");
         else step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), r < 8,
                   8'($urandom), r >= 8 && r < 12);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
